round_robin_arbiter: RTL and testbench
======================================

# round_robin_arbiter

Registered round-robin arbiter that shares one resource among `REQUESTERS` requesters. It produces a one-hot grant vector and the matching binary index, which is the one-hot-to-binary encoding used elsewhere in the library. A grant is held until the owner drops its request. An optional hold limit forces rotation so that one owner cannot starve the others. The block sits in front of any shared datapath (bus, memory port, DSP slice) whose mux select needs a binary index.

## Interface
- `REQUESTERS`, default 8: number of requesters, ≥2.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while others wait, ≥2. Used only with the timeout macro.
- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `request`  in  REQUESTERS: level request per requester.
- `grant`  out  REQUESTERS: registered one-hot grant; all zeros when idle.
- `grantIndex`  out  $clog2(REQUESTERS): binary index of the set `grant` bit; 0 when idle.
- `grantValid`  out  1: high when `grant` is non-zero.

## Operation
- States:
  - IDLE: no owner.
  - GRANTED: one owner.
- Registers:
  - `grant`, `grantIndex`, `grantValid`
  - `lastIndex`: round-robin pointer, the index of the most recent owner.
  - `holdCount`: cycles the current owner has held the grant, 0..MAX_HOLD-1, saturating.
- Arbitration search: scan `request` starting at `(lastIndex+1) mod REQUESTERS` and wrap. The first set bit wins, and the pointer wraps from REQUESTERS-1 to 0.
- IDLE:
  - Any request: arbitrate, load the winner into grant, index and valid, set `lastIndex`=winner, clear `holdCount`, go to GRANTED.
  - No request: stay in IDLE with outputs zero.
- GRANTED, owner's request still high, no forced rotation: hold the grant; `holdCount` increments and saturates.
- GRANTED, owner's request low (release): re-arbitrate in the same cycle over the remaining requests.
  - A winner exists: the new grant takes effect on the next edge, with no idle bubble.
  - No winner: go to IDLE and clear the outputs.
- Simultaneous release and requests: the releasing owner's bit is low, so it cannot win again.
- Output invariants:
  - `grant` is always zero or exactly one-hot.
  - `grantIndex` always equals the encoding of `grant`.
  - `grantValid` equals `|grant`.
- Requests from non-owners never preempt an owner, except through the timeout feature.

## Timing
- Reset (asynchronous, immediate): `grant`=0, `grantIndex`=0, `grantValid`=0, `holdCount`=0, `lastIndex`=REQUESTERS-1 (so requester 0 has first priority), state IDLE.
- Request-to-grant latency: 1 cycle. A request sampled at edge t is granted after edge t.
- Release-to-next-grant latency: 1 cycle. The owner's request low at edge t moves the grant to the next owner after edge t.
- Reset asserted mid-grant clears the grant immediately. After reset deasserts, arbitration restarts from requester 0.
- A request may drop in the same cycle it is granted. The grant lasts one cycle, then releases.

## Configuration
- `ROUND_ROBIN_ARBITER_TIMEOUT_EN`: when defined, forced rotation is enabled.
  - Trigger: in GRANTED, when `holdCount`==MAX_HOLD-1 and another requester is active.
  - Action: re-arbitrate excluding the owner. The owner loses the grant on the next edge, and `lastIndex` advances past it.
  - If no other request is active, the owner keeps the grant and `holdCount` stays saturated.
- When undefined: no counter logic is generated, `holdCount` is tied to 0, and an owner holds the grant indefinitely while its request is high.

## Test plan
- Reset release, then `request`=8'b0000_0001 → after 1 edge `grant`=0x01, `grantIndex`=0, `grantValid`=1.
- `request`=0xFF held, each owner drops its request for one cycle after being granted → grants rotate through 0,1,2,…,7,0 with no idle cycle between owners.
- Owner 3 holds while `request`=0x88 → grant stays 0x08. Owner 3 drops → next grant 0x80 (index 7), then 7 drops → 0x08 again.
- With `ROUND_ROBIN_ARBITER_TIMEOUT_EN` and MAX_HOLD=4, requester 2 holding and requester 5 asserted → grant moves to 0x20 after 4 cycles of ownership. With only requester 2 asserted, the grant is kept indefinitely.
- Reset asserted asynchronously mid-grant (grant=0x10) → outputs go to 0 before the next edge. After release, with `request`=0xFF, the first grant is 0x01.
- Random `request` for 10k cycles, checked every cycle:
  - `grant` is one-hot or zero.
  - `grantIndex` equals the encoding of `grant`.
  - No requester waits more than REQUESTERS-1 ownership turns once it is asserted.

Source files
------------

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter with one-hot grant, binary grant index and hold-until-release ownership.
// Define ROUND_ROBIN_ARBITER_TIMEOUT_EN to force rotation after MAX_HOLD cycles of ownership while others wait.
module round_robin_arbiter #(
  parameter int REQUESTERS = 8,
  parameter int MAX_HOLD   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [REQUESTERS-1:0]         request,
  output logic [REQUESTERS-1:0]         grant,
  output logic [$clog2(REQUESTERS)-1:0] grantIndex,
  output logic                          grantValid
);

  localparam int             IW       = $clog2(REQUESTERS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(REQUESTERS - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  if (REQUESTERS < 2 || MAX_HOLD < 2) begin : g_param_check
    $error("round_robin_arbiter: REQUESTERS and MAX_HOLD must both be at least 2");
  end

  function automatic logic [IW-1:0] next_index(input logic [IW-1:0] idx);
    logic [IW-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + IW'(1);
    end
    return nxt;
  endfunction

  // Returns {found, winner}; the scan starts just after the previous owner and wraps.
  function automatic logic [IW:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                          input logic [IW-1:0]         prev);
    logic          found;
    logic [IW-1:0] pos;
    logic [IW-1:0] win;
    found = 1'b0;
    win   = '0;
    pos   = prev;
    for (int k = 0; k < REQUESTERS; k++) begin
      pos = next_index(pos);
      if (!found && req[pos]) begin
        found = 1'b1;
        win   = pos;
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [REQUESTERS-1:0] index_to_onehot(input logic [IW-1:0] idx);
    logic [REQUESTERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t                state_r;
  state_t                state_s;
  logic [IW-1:0]         last_index_r;
  logic [IW-1:0]         last_index_s;
  logic [REQUESTERS-1:0] grant_s;
  logic [IW-1:0]         grant_index_s;
  logic                  grant_valid_s;
  logic [REQUESTERS-1:0] mask_s;
  logic                  found_s;
  logic [IW-1:0]         win_s;
  logic                  owner_req_s;
  logic                  force_s;
  logic                  rotate_s;
  logic                  arbitrate_s;

  // The owner bit is masked out, so a releasing or rotated-out owner can never win again.
  assign mask_s            = request & ~grant;
  assign {found_s, win_s}  = rr_pick(mask_s, last_index_r);
  assign owner_req_s       = request[grantIndex];
  assign rotate_s          = !owner_req_s || force_s;

`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
  localparam int            HW       = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_count_r;
  logic [HW-1:0] hold_count_s;

  assign force_s = (state_r == GRANTED) && (hold_count_r == HOLD_MAX) && (|mask_s);

  // Hold counter: cleared on every new grant, saturates at MAX_HOLD-1.
  always_comb begin
    hold_count_s = hold_count_r;
    case (state_r)
      IDLE: begin
        hold_count_s = '0;
      end
      GRANTED: begin
        if (rotate_s) begin
          hold_count_s = '0;
        end else if (hold_count_r != HOLD_MAX) begin
          hold_count_s = hold_count_r + HW'(1);
        end else begin
          hold_count_s = hold_count_r;
        end
      end
      default: begin
        hold_count_s = '0;
      end
    endcase
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_count_r <= '0;
    end else begin
      hold_count_r <= hold_count_s;
    end
  end
`else
  assign force_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = GRANTED;
        end else begin
          state_s = IDLE;
        end
      end
      GRANTED: begin
        if (rotate_s && !found_s) begin
          state_s = IDLE;
        end else begin
          state_s = GRANTED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next grant, index, valid and pointer; re-arbitration happens in the release cycle itself.
  always_comb begin
    grant_s       = grant;
    grant_index_s = grantIndex;
    grant_valid_s = grantValid;
    last_index_s  = last_index_r;
    case (state_r)
      IDLE:    arbitrate_s = 1'b1;
      GRANTED: arbitrate_s = rotate_s;
      default: arbitrate_s = 1'b1;
    endcase
    if (arbitrate_s && found_s) begin
      grant_s       = index_to_onehot(win_s);
      grant_index_s = win_s;
      grant_valid_s = 1'b1;
      last_index_s  = win_s;
    end else if (arbitrate_s) begin
      grant_s       = '0;
      grant_index_s = '0;
      grant_valid_s = 1'b0;
      last_index_s  = last_index_r;
    end else begin
      grant_s       = grant;
      grant_index_s = grantIndex;
      grant_valid_s = grantValid;
      last_index_s  = last_index_r;
    end
  end

  // Output and pointer registers; the pointer resets to the top so requester 0 goes first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= '0;
      grantIndex   <= '0;
      grantValid   <= 1'b0;
      last_index_r <= LAST_IDX;
    end else begin
      grant        <= grant_s;
      grantIndex   <= grant_index_s;
      grantValid   <= grant_valid_s;
      last_index_r <= last_index_s;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: directed scenarios plus random requests against a reference model.
module tb_round_robin_arbiter;

  localparam int N  = 8;
  localparam int MH = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  request = '0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grantIndex;
  logic          grantValid;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: current owner (-1 when idle), most recent owner, cycles held.
  int m_owner;
  int m_last;
  int m_held;

  int           wait_turns [N];
  logic [N-1:0] prev_grant;

  round_robin_arbiter #(
    .REQUESTERS(N),
    .MAX_HOLD  (MH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .request   (request),
    .grant     (grant),
    .grantIndex(grantIndex),
    .grantValid(grantValid)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_last     = N - 1;
    m_held     = 0;
    prev_grant = '0;
    for (int j = 0; j < N; j++) wait_turns[j] = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    bit rotate;
    int pick;
    int idx;
    rotate = (m_owner < 0) ? 1'b1 : !r[m_owner];
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
    if (m_owner >= 0 && m_held == MH - 1) begin
      for (int j = 0; j < N; j++) if (j != m_owner && r[j]) rotate = 1'b1;
    end
`endif
    if (rotate) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (pick < 0 && r[idx] && idx != m_owner) pick = idx;
      end
      m_owner = pick;
      m_held  = 0;
      if (pick >= 0) m_last = pick;
    end else if (m_held < MH - 1) begin
      m_held++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_g;
    int           enc;
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    check_value("grant", 32'(grant), 32'(exp_g));
    check_value("grantIndex", 32'(grantIndex), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check_value("grantValid", 32'(grantValid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_value("onehot0", 32'($onehot0(grant)), 32'd1);
    enc = 0;
    for (int i = 0; i < N; i++) if (grant[i]) enc = i;
    check_value("index_encode", 32'(grantIndex), 32'(enc));
    check_value("valid_or", 32'(grantValid), 32'(|grant));
  endtask

  // Counts ownership turns given to others while a requester keeps its request high.
  task automatic track_fairness(input logic [N-1:0] r);
    if (grant != '0 && grant != prev_grant) begin
      for (int j = 0; j < N; j++) begin
        if (r[j] && !grant[j]) begin
          wait_turns[j]++;
          check_value("fair_wait", 32'(wait_turns[j] <= N - 1), 32'd1);
        end
      end
    end
    for (int j = 0; j < N; j++) if (!r[j] || grant[j]) wait_turns[j] = 0;
    prev_grant = grant;
  endtask

  task automatic step(input logic [N-1:0] r);
    request = r;
    @(posedge clk);
    model_edge(r);
    #1;
    compare_all();
    track_fairness(r);
  endtask

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] exp_g;
    logic [N-1:0] r;
    one = 8'h01;
    model_reset();

    #2;
    check_value("reset_grant", 32'(grant), 32'd0);
    check_value("reset_index", 32'(grantIndex), 32'd0);
    check_value("reset_valid", 32'(grantValid), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    step(8'h01);
    check_value("first_grant", 32'(grant), 32'h01);
    check_value("first_index", 32'(grantIndex), 32'd0);
    check_value("first_valid", 32'(grantValid), 32'd1);

    step(8'hFF);
    for (int i = 1; i <= N; i++) begin
      step(8'hFF & ~grant);
      exp_g = one << (i % N);
      check_value("rotate_grant", 32'(grant), 32'(exp_g));
    end

    step(8'h08);
    check_value("owner3_grant", 32'(grant), 32'h08);
    for (int k = 0; k < 3; k++) begin
      step(8'h88);
      check_value("owner3_hold", 32'(grant), 32'h08);
    end
    step(8'h80);
    check_value("owner7_grant", 32'(grant), 32'h80);
    check_value("owner7_index", 32'(grantIndex), 32'd7);
    step(8'h08);
    check_value("owner3_again", 32'(grant), 32'h08);

    step(8'h04);
    check_value("owner2_grant", 32'(grant), 32'h04);
    for (int k = 1; k <= 4; k++) begin
      step(8'h24);
`ifdef ROUND_ROBIN_ARBITER_TIMEOUT_EN
      exp_g = (k == 4) ? 8'h20 : 8'h04;
`else
      exp_g = 8'h04;
`endif
      check_value("hold_limit", 32'(grant), 32'(exp_g));
    end
    for (int k = 0; k < 10; k++) begin
      step(8'h04);
      check_value("sole_owner_keeps", 32'(grant), 32'h04);
    end

    step(8'h10);
    check_value("pre_reset_grant", 32'(grant), 32'h10);
    #2 reset_n = 1'b0;
    #1;
    check_value("async_reset_grant", 32'(grant), 32'd0);
    check_value("async_reset_index", 32'(grantIndex), 32'd0);
    check_value("async_reset_valid", 32'(grantValid), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(8'hFF);
    check_value("post_reset_first", 32'(grant), 32'h01);

    for (int c = 0; c < 10000; c++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
      if ($urandom_range(0, 1) == 1) r = r | grant;
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
